// File: rtl/countdown_timer.sv
// Loadable down-counter with start/done/ack handshake for timeouts and programmed delays.
// Define COUNTDOWN_AUTO_RELOAD_EN for periodic mode: reload on expiry with a one-cycle done pulse.
module countdown_timer #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             dec,
  input  logic             ack,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    // NOTE: every _d gets a hold default first so no path through the case infers a latch.
    state_d  = state_q;
    q_d      = q_q;
    reload_d = reload_q;
    busy_d   = busy_q;
    done_d   = done_q;

    if (stop) begin
      state_d = IDLE;
      q_d     = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else if (start) begin
      // A start in any state loads; in DONE it doubles as the acknowledge.
      if (D != '0) begin
        state_d  = RUN;
        q_d      = D;
        reload_d = D;
        busy_d   = 1'b1;
        done_d   = 1'b0;
      end else begin
        state_d = DONE;
        q_d     = '0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          busy_d = 1'b0;
          done_d = 1'b0;
        end
        RUN: begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          done_d = 1'b0;
`endif
          if (dec) begin
            // Expiry is caught at one so the count never wraps below zero.
            if (q_q == WIDTH'(1)) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              q_d    = reload_q;
              done_d = 1'b1;
`else
              state_d = DONE;
              q_d     = '0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
`endif
            end else begin
              q_d = q_q - WIDTH'(1);
            end
          end
        end
        DONE: begin
          if (ack) begin
            state_d = IDLE;
            done_d  = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          q_d     = '0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous, sampled on the edge.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q  <= IDLE;
      q_q      <= '0;
      reload_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      reload_q <= reload_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Q    = q_q;
  assign busy = busy_q;
  assign done = done_q;
  assign zero = (q_q == '0);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: hand-computed expectations sampled 1ns after each rising edge.
module tb_countdown_timer;

  logic       CLK = 1'b0;
  logic       reset, start, stop, dec, ack;
  logic [7:0] D;
  logic [7:0] Q;
  logic       busy, done, zero;

  int n_vec = 0;
  int n_err = 0;

  countdown_timer #(.WIDTH(8)) dut (
    .CLK  (CLK),
    .reset(reset),
    .start(start),
    .stop (stop),
    .dec  (dec),
    .ack  (ack),
    .D    (D),
    .Q    (Q),
    .busy (busy),
    .done (done),
    .zero (zero)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [7:0] eq, input logic eb,
                             input logic ed);
    check({tag, ".Q"}, 32'(Q), 32'(eq));
    check({tag, ".busy"}, 32'(busy), 32'(eb));
    check({tag, ".done"}, 32'(done), 32'(ed));
    check({tag, ".zero"}, 32'(zero), 32'(eq == 8'h00));
  endtask

  initial begin
    int edges;
    reset = 1'b0; start = 1'b0; stop = 1'b0; dec = 1'b0; ack = 1'b0; D = 8'h00;

    // Reset state
    tick();
    check_state("reset", 8'h00, 1'b0, 1'b0);
    reset = 1'b1;

`ifndef COUNTDOWN_AUTO_RELOAD_EN
    // One-shot expiry with dec held
    start = 1'b1; D = 8'h03; dec = 1'b1;
    tick(); check_state("os_load", 8'h03, 1'b1, 1'b0);
    start = 1'b0;
    tick(); check_state("os_2", 8'h02, 1'b1, 1'b0);
    tick(); check_state("os_1", 8'h01, 1'b1, 1'b0);
    tick(); check_state("os_exp", 8'h00, 1'b0, 1'b1);
    tick(); check_state("os_hold", 8'h00, 1'b0, 1'b1);
    dec = 1'b0; ack = 1'b1;
    tick(); check_state("os_ack", 8'h00, 1'b0, 1'b0);
    ack = 1'b0;
`endif

    // Tick gating: dec = 1,0,0,1
    start = 1'b1; D = 8'h05;
    tick(); check_state("gate_load", 8'h05, 1'b1, 1'b0);
    start = 1'b0; dec = 1'b1;
    tick(); check_state("gate_d1", 8'h04, 1'b1, 1'b0);
    dec = 1'b0;
    tick(); check_state("gate_d0a", 8'h04, 1'b1, 1'b0);
    ack = 1'b1;  // ack in RUN has no effect
    tick(); check_state("gate_d0b", 8'h04, 1'b1, 1'b0);
    ack = 1'b0; dec = 1'b1;
    tick(); check_state("gate_d1b", 8'h03, 1'b1, 1'b0);
    tick(); check_state("rs_pre", 8'h02, 1'b1, 1'b0);

    // Restart in RUN: load wins over dec
    start = 1'b1; D = 8'h0A;
    tick(); check_state("restart", 8'h0A, 1'b1, 1'b0);
    start = 1'b0; dec = 1'b0;

    // Zero load goes straight to DONE; restart from RUN with D=0 too
    start = 1'b1; D = 8'h00;
    tick(); check_state("zero_load", 8'h00, 1'b0, 1'b1);
    start = 1'b0;
    tick(); check_state("zero_hold", 8'h00, 1'b0, 1'b1);
    // start in DONE is an implicit ack and loads
    start = 1'b1; D = 8'h41;
    tick(); check_state("done_start", 8'h41, 1'b1, 1'b0);
    start = 1'b0; dec = 1'b1;
    tick(); check_state("pre_stop", 8'h40, 1'b1, 1'b0);

    // stop with start: stop wins
    stop = 1'b1; start = 1'b1; D = 8'h07;
    tick(); check_state("stop", 8'h00, 1'b0, 1'b0);
    stop = 1'b0; start = 1'b0; ack = 1'b1;
    // dec and ack ignored in IDLE
    tick(); check_state("idle_ign", 8'h00, 1'b0, 1'b0);
    ack = 1'b0; dec = 1'b0;

    // Reset mid-count overrides start
    start = 1'b1; D = 8'h21;
    tick(); start = 1'b0; dec = 1'b1;
    tick(); check_state("pre_rst", 8'h20, 1'b1, 1'b0);
    reset = 1'b0; start = 1'b1; D = 8'h09;
    tick(); check_state("mid_rst", 8'h00, 1'b0, 1'b0);
    reset = 1'b1; start = 1'b0; dec = 1'b0;
    tick(); check_state("post_rst", 8'h00, 1'b0, 1'b0);

`ifndef COUNTDOWN_AUTO_RELOAD_EN
    // Full-scale load: done after exactly 255 enabled edges
    start = 1'b1; D = 8'hFF;
    tick(); check_state("ff_load", 8'hFF, 1'b1, 1'b0);
    start = 1'b0; dec = 1'b1;
    edges = 0;
    while (done !== 1'b1 && edges < 300) begin
      tick();
      edges++;
    end
    check("ff_edges", 32'(edges), 32'd255);
    check_state("ff_exp", 8'h00, 1'b0, 1'b1);
    tick(); check_state("ff_nounder", 8'h00, 1'b0, 1'b1);
    dec = 1'b0; ack = 1'b1;
    tick(); check_state("ff_ack", 8'h00, 1'b0, 1'b0);
    ack = 1'b0;
`else
    // Periodic mode: 2,1,2,1,2 with a done pulse on each reload edge
    start = 1'b1; D = 8'h02; dec = 1'b1;
    tick(); check_state("ar_load", 8'h02, 1'b1, 1'b0);
    start = 1'b0;
    tick(); check_state("ar_1a", 8'h01, 1'b1, 1'b0);
    ack = 1'b1;
    tick(); check_state("ar_rl1", 8'h02, 1'b1, 1'b1);
    tick(); check_state("ar_1b", 8'h01, 1'b1, 1'b0);
    tick(); check_state("ar_rl2", 8'h02, 1'b1, 1'b1);
    ack = 1'b0; dec = 1'b0;
    tick(); check_state("ar_hold", 8'h02, 1'b1, 1'b0);
    start = 1'b1; D = 8'h00;
    tick(); check_state("ar_zero", 8'h00, 1'b0, 1'b1);
    start = 1'b0;
    tick(); check_state("ar_zwait", 8'h00, 1'b0, 1'b1);
    ack = 1'b1;
    tick(); check_state("ar_zack", 8'h00, 1'b0, 1'b0);
    ack = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

- Loadable WIDTH-bit down-counter with a start/done/ack handshake.
- Acts as the consuming counterpart to the team's load/increment up-counter register.
  - A value is loaded, then drained by one per enabled tick.
  - Expiry at zero is reported to a controller, which acknowledges it.
- Sits beside the up-counter in the datapath and provides timeouts and programmed delays.

## Interface

Parameters:
- WIDTH, default 8: counter and load-data width.

Ports:
- CLK, input, 1: single clock; every flop updates on its rising edge.
- reset, input, 1: synchronous, active-low reset. Low at a CLK rising edge resets the block.
- start, input, 1: load D and begin counting.
- stop, input, 1: abort and return to IDLE.
- dec, input, 1: tick enable; each high cycle in RUN decrements Q by 1.
- ack, input, 1: acknowledges done.
- D, input, WIDTH: load value, sampled when start is accepted.
- Q, output, WIDTH: current count, registered.
- busy, output, 1: high in RUN, registered.
- done, output, 1: expiry flag, registered.
- zero, output, 1: combinational (Q == 0).

## Operation

- States: IDLE, RUN, DONE.
- Priority at each edge: reset low > stop > start > dec/ack.
- Reset (reset=0 at an edge):
  - Q=0, busy=0, done=0, state IDLE.
  - Internal reload register = 0.
  - zero therefore reads 1.
- IDLE:
  - start=1 with D≠0: Q<=D, reload<=D, go to RUN, busy=1.
  - start=1 with D=0: Q<=0, go directly to DONE, done=1.
  - dec and ack are ignored.
- RUN:
  - dec=1 and Q>1: Q<=Q-1.
  - dec=1 and Q==1: Q<=0, go to DONE, done=1, busy=0.
  - dec=0: Q holds.
  - start=1 restarts: Q<=D, reload<=D, and dec is ignored that cycle. D=0 goes to DONE, as in IDLE.
- DONE:
  - Q held at 0, done held at 1 until ack=1.
  - ack=1 (start=0): go to IDLE next edge, done=0.
  - start=1 acts as an implicit ack and loads exactly as in IDLE.
- stop=1 in any state: go to IDLE, Q<=0, busy=0, done=0.
- Arithmetic is modulo 2^WIDTH. Q never decrements below 0, because expiry is detected at Q==1.

## Timing

- All outputs except zero change only on CLK rising edges.
- Start latency: start sampled at edge k gives Q=D and busy=1 after edge k. The first decrement can occur at edge k+1.
- Loading N≠0 followed by continuous dec: done rises after edge k+N, on the same edge that Q becomes 0.
- Done/ack: ack sampled at edge m gives done=0 after edge m. ack held high in IDLE or RUN has no effect.
- start and dec high together in RUN: the load wins and no decrement occurs.
- stop and start high together: stop wins and the block ends in IDLE.
- reset low mid-count: the reset values above take effect after that edge, regardless of other inputs.

## Configuration

- Macro: COUNTDOWN_AUTO_RELOAD_EN.
- Defined:
  - In RUN, dec=1 with Q==1 sets Q<=reload, stays in RUN with busy=1, and pulses done high for exactly one cycle.
  - ack is ignored, and the periodic expiry repeats until stop or a new start.
  - A load of D=0 still goes to DONE and waits for ack, as in the undefined case.
- Undefined: the one-shot behaviour described under Operation applies.

## Test plan

- Reset and one-shot expiry:
  - Stimulus: reset=0 for 1 cycle, then start with D=8'h03, dec held 1.
  - Expect Q=0, zero=1 after reset.
  - Then Q=3,2,1,0 on consecutive edges; done=1 and busy=0 on the edge Q reaches 0.
  - ack=1 for one cycle then gives done=0 in IDLE.
- Tick gating: start with D=8'h05, then dec=1,0,0,1 → Q=5,4,4,4,3.
- Zero load and restart:
  - start with D=8'h00 → DONE immediately, done=1, Q=0.
  - start in RUN at Q=8'h02 with D=8'h0A and dec=1 → Q=8'h0A, no decrement that cycle.
- Abort and reset:
  - stop=1 at Q=8'h40 together with start=1 → IDLE, Q=0, busy=0.
  - reset=0 at Q=8'h20 in RUN → Q=0, busy=0, done=0.
- Wrap values: start with D=8'hFF and dec held 1 → done after exactly 255 enabled edges, with no underflow past 0.
- With COUNTDOWN_AUTO_RELOAD_EN defined:
  - start with D=8'h02 and dec held 1 → Q=2,1,2,1,2…
  - done is a 1-cycle pulse on each reload edge and busy stays 1.
